// File: rtl/mclaurin_result_fifo.sv
// rtl/mclaurin_result_fifo.sv - FWFT result FIFO with drop/overflow statistics for the McLaurin pipeline
// Optional feature macro: MCL_RESULT_SAT_EN (store overflowed results as all-ones).
module mclaurin_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_y,
  input  logic                     in_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_y,
  output logic                     out_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_y   [DEPTH];
  logic              mem_ovf [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [DATA_W-1:0] wdata;
  logic              pop;
  logic              push;
  logic              drop;
  logic              head_from_input;
  logic              head_from_mem;

`ifdef MCL_RESULT_SAT_EN
  assign wdata = in_ovf ? {DATA_W{1'b1}} : in_y;
`else
  assign wdata = in_y;
`endif

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;
  assign rd_next   = rd_ptr + PTR_W'(1);

  // The head register is refilled from the input when the FIFO is (or is about
  // to become) otherwise empty, else from the entry behind the popped head.
  assign head_from_input = push & (empty | (pop & (level == LVL_W'(1))));
  assign head_from_mem   = pop & (level > LVL_W'(1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]   <= wdata;
      mem_ovf[wr_ptr] <= in_ovf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      out_y    <= '0;
      out_ovf  <= 1'b0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (head_from_input) begin
        out_y   <= wdata;
        out_ovf <= in_ovf;
      end else if (head_from_mem) begin
        out_y   <= mem_y[rd_next];
        out_ovf <= mem_ovf[rd_next];
      end

      // Statistics saturate rather than wrap.
      if (drop && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
      if (push && in_ovf && (ovf_cnt != {CNT_W{1'b1}}))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mclaurin_result_fifo.sv
// tb/tb_mclaurin_result_fifo.sv - self-checking bench for mclaurin_result_fifo
module tb_mclaurin_result_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
`ifdef MCL_RESULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_y;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_ovf;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] ovf_cnt;

  mclaurin_result_fifo #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_y(in_y), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf),
    .full(full), .empty(empty), .level(level), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
  } ent_t;

  ent_t q[$];
  int   m_drop;
  int   m_ovf;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("level", 64'(level), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    if (q.size() != 0) begin
      chk("out_y", 64'(out_y), 64'(q[0].y));
      chk("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
    end
  endtask

  // Called at a falling edge; applies inputs for one rising edge, then checks.
  task automatic step(input logic v, input logic [31:0] y, input logic o, input logic r);
    bit   p_pop;
    bit   p_push;
    ent_t e;
    in_valid  = v;
    in_y      = y;
    in_ovf    = o;
    out_ready = r;
    p_pop  = (q.size() > 0) && r;
    p_push = v && ((q.size() < DEPTH) || p_pop);
    if (v && !p_push && m_drop < CMAX) m_drop++;
    if (p_pop) void'(q.pop_front());
    if (p_push) begin
      e.y   = (o && SAT) ? 32'hFFFF_FFFF : y;
      e.ovf = o;
      q.push_back(e);
      if (o && m_ovf < CMAX) m_ovf++;
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    q.delete();
    m_drop = 0;
    m_ovf  = 0;
    @(negedge clk);
    reset = 1'b1;
    check_model();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_y      = '0;
    in_ovf    = 1'b0;
    out_ready = 1'b0;
    m_drop    = 0;
    m_ovf     = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_y", 64'(out_y), 64'h0);
    chk("rst_out_ovf", 64'(out_ovf), 64'h0);
    reset = 1'b1;
    check_model();

    // 1: single push, held for 5 cycles
    step(1'b1, 32'h10, 1'b0, 1'b0);
    chk("t1_valid", 64'(out_valid), 64'h1);
    chk("t1_y", 64'(out_y), 64'h10);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t1_hold_y", 64'(out_y), 64'h10);

    // 2: fill, drop one, drain in order
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("t2_full", 64'(full), 64'h1);
    step(1'b1, 32'h9, 1'b0, 1'b0);
    chk("t2_drop", 64'(drop_cnt), 64'h1);
    chk("t2_level", 64'(level), 64'h8);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_order", 64'(out_y), 64'(i));
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("t2_empty", 64'(empty), 64'h1);

    // 3: simultaneous push/pop while full
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 9; i <= 12; i++) step(1'b1, 32'(i), 1'b0, 1'b1);
    chk("t3_level", 64'(level), 64'h8);
    chk("t3_drop", 64'(drop_cnt), 64'h0);
    chk("t3_head", 64'(out_y), 64'h5);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);

    // 4: overflowed result
    do_reset();
    step(1'b1, 32'h1234, 1'b1, 1'b0);
    chk("t4_ovf_cnt", 64'(ovf_cnt), 64'h1);
    chk("t4_out_ovf", 64'(out_ovf), 64'h1);
    chk("t4_out_y", 64'(out_y), SAT ? 64'hFFFF_FFFF : 64'h1234);

    // 5: reset mid-drain
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'(32'h50 + i), 1'(i == 2), 1'b0);
    step(1'b1, 32'h60, 1'b0, 1'b1);
    out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", 64'(out_valid), 64'h0);
    chk("t5_level", 64'(level), 64'h0);
    chk("t5_drop", 64'(drop_cnt), 64'h0);
    chk("t5_ovf", 64'(ovf_cnt), 64'h0);
    q.delete();
    m_drop = 0;
    m_ovf  = 0;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_model();
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk("t5_first", 64'(out_y), 64'h77);

    // 6: drop counter saturation
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
    chk("t6_drop_sat", 64'(drop_cnt), 64'hF);

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 4) != 0), $urandom, 1'(($urandom % 5) == 0), 1'(($urandom % 3) != 0));
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rand_drained", 64'(empty), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
